// File: rtl/cross_bar_pkg.sv
// Shared cross-bar types plus the slave-memory additions: state enum,
// default error data and the out-of-range address mask helper.
package cross_bar_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SLAVE_W = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } slv_state_t;

    localparam data_t XBAR_SLV_ERR_DATA = 32'hDEAD_BEEF;

    // Bits between the word index and the slave-select field; any of them
    // set means the address lies beyond the RAM. Empty mask when the
    // index reaches the slave-select field.
    function automatic addr_t range_mask(input int idx_w);
        addr_t m;
        m = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (b >= idx_w + 2 && b < ADDR_W - SLAVE_W) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/xbar_slave_mem_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W. One access per cycle:
// write when en&we, read into the registered output when en&!we.
// Read register is reset; array contents are not.
module xbar_slave_mem_ram
    import cross_bar_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  data_t            i_wdata,
    output data_t            o_rdata
);

    data_t r_mem [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Registered read data, held until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rdata <= '0;
        end else if (i_en && !i_we) begin
            o_rdata <= r_mem[i_idx];
        end
    end

endmodule

// File: rtl/xbar_slave_mem.sv
// Cross-bar slave endpoint: word-addressed RAM with per-transaction
// programmable ack latency, address range check with error data and
// optional statistics counters (enabled by defining XBAR_SLV_STATS_EN).
//
// Handshake: a request is accepted on any edge where the FSM is IDLE and
// slave_req=1; slave_ack is a one-cycle pulse 1+cfg_wait cycles later,
// with slave_rdata/slave_err valid in that cycle. Request fields and
// cfg_wait are only looked at in IDLE.
module xbar_slave_mem
    import cross_bar_pkg::*;
#(
    parameter int    DEPTH    = 256,
    parameter int    WAIT_W   = 4,
    parameter data_t ERR_DATA = XBAR_SLV_ERR_DATA,
    parameter int    CNT_W    = 16
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              slave_req,
    input  addr_t             slave_addr,
    input  logic              slave_cmd,
    input  data_t             slave_wdata,
    output logic              slave_ack,
    output data_t             slave_rdata,
    input  logic [WAIT_W-1:0] cfg_wait,
    output logic              slave_err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int    IDX_W      = $clog2(DEPTH);
    localparam addr_t RANGE_MASK = range_mask(IDX_W);

    slv_state_t        r_state;
    logic [WAIT_W-1:0] r_cnt;
    addr_t             r_addr;
    logic              r_cmd;
    data_t             r_wdata;
    logic              r_err;
    logic              r_rd_err;

    logic              w_accept;
    logic              w_commit;
    addr_t             w_addr;
    logic              w_cmd;
    data_t             w_wdata;
    logic              w_oor;
    logic [IDX_W-1:0]  w_idx;
    data_t             w_ram_rdata;

    // With cfg_wait=0 the commit edge is the accept edge, so the live
    // request fields feed the RAM; otherwise the captured copy does.
    assign w_accept = (r_state == IDLE) && slave_req;
    assign w_commit = (w_accept && (cfg_wait == '0)) ||
                      ((r_state == WAIT) && (r_cnt == WAIT_W'(1)));
    assign w_addr   = (r_state == IDLE) ? slave_addr  : r_addr;
    assign w_cmd    = (r_state == IDLE) ? slave_cmd   : r_cmd;
    assign w_wdata  = (r_state == IDLE) ? slave_wdata : r_wdata;
    assign w_oor    = |(w_addr & RANGE_MASK);
    assign w_idx    = w_addr[IDX_W+1:2];

    xbar_slave_mem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst     (areset),
        .i_en    (w_commit && !w_oor),
        .i_we    (w_cmd),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    // FSM and wait counter: IDLE -> (WAIT) -> ACK -> IDLE
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (slave_req) begin
                        r_cnt   <= cfg_wait;
                        r_state <= (cfg_wait == '0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == WAIT_W'(1)) begin
                        r_state <= ACK;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Capture the request fields at accept
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_addr  <= '0;
            r_cmd   <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= slave_addr;
            r_cmd   <= slave_cmd;
            r_wdata <= slave_wdata;
        end
    end

    // Record range status at commit; a read also decides the rdata source
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_err    <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (w_commit) begin
            r_err <= w_oor;
            if (!w_cmd) begin
                r_rd_err <= w_oor;
            end
        end
    end

    assign slave_ack   = (r_state == ACK);
    assign slave_err   = slave_ack && r_err;
    assign slave_rdata = r_rd_err ? ERR_DATA : w_ram_rdata;

`ifdef XBAR_SLV_STATS_EN
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // Saturating per-class completion counters, stepped in the ACK cycle
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (r_state == ACK) begin
            if (r_err) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end else if (r_cmd) begin
                if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
            end else begin
                if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    assign wr_cnt  = r_wr_cnt;
    assign rd_cnt  = r_rd_cnt;
    assign err_cnt = r_err_cnt;
`else
    assign wr_cnt  = '0;
    assign rd_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Bench for xbar_slave_mem (DEPTH=256, WAIT_W=4, CNT_W=2). Statistics
// expectations follow XBAR_SLV_STATS_EN when it is defined for the build.
module tb_xbar_slave_mem;
    import cross_bar_pkg::*;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             areset = 1'b1;
    logic             slave_req = 1'b0;
    addr_t            slave_addr = '0;
    logic             slave_cmd = 1'b0;
    data_t            slave_wdata = '0;
    logic             slave_ack;
    data_t            slave_rdata;
    logic [3:0]       cfg_wait = '0;
    logic             slave_err;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] err_cnt;

    xbar_slave_mem #(
        .DEPTH    (256),
        .WAIT_W   (4),
        .ERR_DATA (32'hDEAD_BEEF),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .slave_req   (slave_req),
        .slave_addr  (slave_addr),
        .slave_cmd   (slave_cmd),
        .slave_wdata (slave_wdata),
        .slave_ack   (slave_ack),
        .slave_rdata (slave_rdata),
        .cfg_wait    (cfg_wait),
        .slave_err   (slave_err),
        .wr_cnt      (wr_cnt),
        .rd_cnt      (rd_cnt),
        .err_cnt     (err_cnt)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    typedef struct {
        int    ack_cyc;
        logic  err;
        logic  is_rd;
        logic  is_wr;
        data_t rdata;
    } exp_t;

    exp_t  exp_q[$];
    data_t mem_model [int];
    data_t hold_rdata = '0;
    int    exp_wr = 0, exp_rd = 0, exp_err = 0;
    int    n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // 256 words, slave select in bits [31:30]; bits [29:10] must be zero
    function automatic logic in_range(input addr_t a);
        return ((a & 32'h3FFF_FFFF) >> 10) == 0;
    endfunction

    function automatic int word_of(input addr_t a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_push(input logic cmd, input addr_t a, input data_t wd, input int ack_cyc);
        exp_t e;
        e.ack_cyc = ack_cyc;
        e.err     = !in_range(a);
        e.is_rd   = !cmd;
        e.is_wr   = cmd;
        e.rdata   = '0;
        if (!cmd) e.rdata = in_range(a) ? mem_model[word_of(a)] : 32'hDEAD_BEEF;
        if (cmd && in_range(a)) mem_model[word_of(a)] = wd;
        exp_q.push_back(e);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!areset) begin
            check("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
            check("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
            check("err_cnt", 32'(err_cnt), 32'(exp_err));
            if (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_ack: expected ack in cycle %0d, still absent at cycle %0d", exp_q[0].ack_cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].ack_cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack", 32'(slave_ack), 32'd1);
                check("err", 32'(slave_err), 32'(e.err));
                if (e.is_rd) hold_rdata = e.rdata;
                check("rdata", slave_rdata, hold_rdata);
`ifdef XBAR_SLV_STATS_EN
                if (e.err) exp_err = sat(exp_err);
                else if (e.is_wr) exp_wr = sat(exp_wr);
                else exp_rd = sat(exp_rd);
`endif
            end else begin
                check("ack_idle", 32'(slave_ack), 32'd0);
                check("err_idle", 32'(slave_err), 32'd0);
                check("rdata_hold", slave_rdata, hold_rdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call in an IDLE cycle (just after a posedge); returns in the first
    // IDLE cycle after the ack.
    task automatic access(input logic cmd, input addr_t a, input data_t wd,
                          input int w, input int w_after);
        slave_req   = 1'b1;
        slave_cmd   = cmd;
        slave_addr  = a;
        slave_wdata = wd;
        cfg_wait    = 4'(w);
        model_push(cmd, a, wd, cyc + 1 + w);
        @(posedge clk); #1;
        slave_req   = 1'b0;
        slave_addr  = $urandom;
        slave_wdata = $urandom;
        slave_cmd   = 1'($urandom_range(0, 1));
        cfg_wait    = 4'(w_after);
        repeat (w + 1) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        slave_req = 1'b0;
        exp_q.delete();
        hold_rdata = '0;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_ack", 32'(slave_ack), 32'd0);
        check("rst_err", 32'(slave_err), 32'd0);
        check("rst_rdata", slave_rdata, 32'h0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);

        // 1: zero-wait write then read
        access(1'b1, 32'h0000_0010, 32'h0123_4567, 0, 0);
        access(1'b0, 32'h0000_0010, 32'h0, 0, 0);
        check("t1_rdata_lit", slave_rdata, 32'h0123_4567);

        // 2: five wait cycles, cfg_wait changed during WAIT; ignored addr bits
        access(1'b0, 32'h0000_0010, 32'h0, 5, 0);
        access(1'b0, 32'hC000_0013, 32'h0, 1, 3);
        check("t2_alias_lit", slave_rdata, 32'h0123_4567);

        // 3: out-of-range accesses and range boundaries
        access(1'b1, 32'h0000_0000, 32'hA5A5_0000, 0, 0);
        access(1'b1, 32'h0000_0400, 32'h5A5A_5A5A, 2, 0);
        access(1'b0, 32'h0000_0000, 32'h0, 0, 0);
        check("t3_ram_kept_lit", slave_rdata, 32'hA5A5_0000);
        access(1'b0, 32'h0000_0400, 32'h0, 0, 0);
        check("t3_errdata_lit", slave_rdata, 32'hDEAD_BEEF);
        access(1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1, 0);
        access(1'b0, 32'h0000_03FC, 32'h0, 0, 0);
        check("t3_top_word_lit", slave_rdata, 32'hCAFE_F00D);
        access(1'b0, 32'h2000_03FC, 32'h0, 3, 0);

        // 4: request held high across the ack -> second write
        k = cyc;
        slave_req = 1'b1; slave_cmd = 1'b1;
        slave_addr = 32'h0000_0008; slave_wdata = 32'h00FF_00FF; cfg_wait = 4'd0;
        model_push(1'b1, 32'h0000_0008, 32'h00FF_00FF, k + 1);
        model_push(1'b1, 32'h0000_0008, 32'h00FF_00FF, k + 3);
        repeat (3) @(posedge clk);
        #1;
        slave_req = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 32'h0000_0008, 32'h0, 0, 0);

        // 5: reset during WAIT drops the pending write
        access(1'b1, 32'h0000_000C, 32'h1111_2222, 0, 0);
        slave_req = 1'b1; slave_cmd = 1'b1;
        slave_addr = 32'h0000_000C; slave_wdata = 32'hFFFF_FFFF; cfg_wait = 4'd5;
        @(posedge clk); #1;
        slave_req = 1'b0;
        @(posedge clk); #1;
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        access(1'b0, 32'h0000_000C, 32'h0, 0, 0);
        check("t5_prior_lit", slave_rdata, 32'h1111_2222);

        // 6: five in-range writes saturate a 2-bit write counter
        for (int i = 0; i < 5; i++) begin
            access(1'b1, addr_t'(32'h20 + 4 * i), data_t'(i + 1), 0, 0);
        end
        @(posedge clk); #1;
`ifdef XBAR_SLV_STATS_EN
        check("t6_wr_sat_lit", 32'(wr_cnt), 32'd3);
`else
        check("t6_wr_zero_lit", 32'(wr_cnt), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_acks: %0d expected acks never seen", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
